// File: rtl/mem_transpose_buf.sv
// mem_transpose_buf: ping-pong 4x4 transpose of A/S row words into column operand pairs
module mem_transpose_buf #(
    parameter int DATA_W = 64,
    parameter int ELEM_W = 16,
    parameter int LANES  = 4,
    localparam int CW    = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calc_init,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_s,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              overflow
);
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    logic [DATA_W-1:0] bank_a [2][LANES];
    logic [DATA_W-1:0] bank_s [2][LANES];
    logic [CW-1:0]     wr_cnt, rd_col, ld_col;
    logic              wr_bank, rd_bank;
    logic [1:0]        full, full_next;
    rstate_t           state;
    logic              wr_en, wr_last, free, load, done;
    logic [DATA_W-1:0] col_a, col_s;

    always_comb begin
        in_ready  = !full[wr_bank];
        wr_en     = in_valid && in_ready && !calc_init;
        wr_last   = wr_en && wr_cnt == CW'(LANES - 1);
        free      = !out_valid || out_ready;
        ld_col    = (state == R_IDLE) ? '0 : rd_col;
        load      = free && full[rd_bank];
        done      = load && ld_col == CW'(LANES - 1);
        full_next = full;
        if (done)
            full_next[rd_bank] = 1'b0;
        if (wr_last)
            full_next[wr_bank] = 1'b1;
        col_a = '0;
        col_s = '0;
        for (int r = 0; r < LANES; r++) begin
            col_a[ELEM_W*r +: ELEM_W] = bank_a[rd_bank][r][ELEM_W*ld_col +: ELEM_W];
            col_s[ELEM_W*r +: ELEM_W] = bank_s[rd_bank][r][ELEM_W*ld_col +: ELEM_W];
        end
    end

    // Bank contents survive reset; full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_a[wr_bank][wr_cnt] <= in_data_a;
            bank_s[wr_bank][wr_cnt] <= in_data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || calc_init) begin
            wr_cnt    <= '0;
            rd_col    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= '0;
            state     <= R_IDLE;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            full <= full_next;
            if (wr_en)
                wr_cnt <= wr_cnt + 1'b1;
            if (wr_last)
                wr_bank <= !wr_bank;
            if (in_valid && !in_ready)
                overflow <= 1'b1;
            if (load) begin
                out_valid <= 1'b1;
                out_left  <= col_a;
                out_right <= col_s;
                out_col   <= ld_col;
                out_last  <= done;
                rd_col    <= ld_col + 1'b1;
                state     <= R_DRAIN;
                if (done) begin
                    rd_bank <= !rd_bank;
                    state   <= full[!rd_bank] ? R_DRAIN : R_IDLE;
                end
            end else if (free) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_transpose_buf.sv
// tb_mem_transpose_buf: directed checks of fill, drain, backpressure, overflow and restart
module tb_mem_transpose_buf;
    logic        clk = 1'b0;
    logic        rst, calc_init, in_valid, out_ready;
    logic [63:0] in_data_a, in_data_s;
    logic        in_ready, out_valid, out_last, overflow;
    logic [63:0] out_left, out_right;
    logic [1:0]  out_col;
    int          n_tests = 0, n_fail = 0;
    int          exp_n, gb, gaps;
    bit          started;

    mem_transpose_buf dut (
        .clk(clk), .rst(rst), .calc_init(calc_init), .in_valid(in_valid),
        .in_data_a(in_data_a), .in_data_s(in_data_s), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_left(out_left),
        .out_right(out_right), .out_col(out_col), .out_last(out_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] row_w(input int g, input int r, input int s);
        logic [63:0] w;
        for (int e = 0; e < 4; e++)
            w[16*e +: 16] = 16'(g*16 + 4*r + e + 256*s);
        return w;
    endfunction

    function automatic logic [63:0] col_w(input int g, input int c, input int s);
        logic [63:0] w;
        for (int r = 0; r < 4; r++)
            w[16*r +: 16] = 16'(g*16 + 4*r + c + 256*s);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input int r);
        in_valid  = 1'b1;
        in_data_a = row_w(g, r, 0);
        in_data_s = row_w(g, r, 1);
        tick();
    endtask

    // Scores the column about to be accepted at the coming edge.
    task automatic acc();
        int g, c;
        if (out_valid && out_ready) begin
            g = gb + exp_n / 4;
            c = exp_n % 4;
            check("col", 64'(out_col), 64'(c));
            check("left", out_left, col_w(g, c, 0));
            check("right", out_right, col_w(g, c, 1));
            check("last", 64'(out_last), 64'(c == 3));
            exp_n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; calc_init = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data_a = '0; in_data_s = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_left", out_left, 0);
        check("rst_right", out_right, 0);
        check("rst_ovf", 64'(overflow), 0);
        check("rst_rdy", 64'(in_ready), 1);

        // single group, latency and literal column 0
        for (int r = 0; r < 4; r++) drive(0, r);
        in_valid = 1'b0;
        check("lat_early", 64'(out_valid), 0);
        tick();
        check("g0_valid", 64'(out_valid), 1);
        check("g0_left", out_left, 64'h000C_0008_0004_0000);
        check("g0_right", out_right, 64'h010C_0108_0104_0100);
        check("g0_col", 64'(out_col), 0);
        check("g0_last", 64'(out_last), 0);
        for (int c = 1; c < 4; c++) begin
            tick();
            check("g0_coln", 64'(out_col), 64'(c));
            check("g0_leftn", out_left, col_w(0, c, 0));
            check("g0_lastn", 64'(out_last), 64'(c == 3));
        end
        tick();
        check("g0_done", 64'(out_valid), 0);

        // eight groups back to back
        gb = 1; exp_n = 0; gaps = 0; started = 0;
        for (int i = 0; i < 48; i++) begin
            if (i >= 32 && exp_n >= 32) break;
            if (out_valid) started = 1;
            else if (started && exp_n < 32) gaps++;
            acc();
            if (i < 32) begin
                in_valid  = 1'b1;
                in_data_a = row_w(gb + i/4, i%4, 0);
                in_data_s = row_w(gb + i/4, i%4, 1);
                check("b2b_rdy", 64'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(exp_n), 32);
        check("b2b_gaps", 64'(gaps), 0);
        check("b2b_ovf", 64'(overflow), 0);

        // stalled consumer, 12 words offered
        calc_init = 1'b1; tick(); calc_init = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("stall_rdy", 64'(in_ready), 64'(i < 8));
            if (i == 8) check("stall_ovf_early", 64'(overflow), 0);
            drive(i/4, i%4);
        end
        in_valid = 1'b0;
        check("stall_ovf", 64'(overflow), 1);
        check("stall_valid", 64'(out_valid), 1);
        check("stall_left", out_left, col_w(0, 0, 0));
        tick(); tick();
        check("stall_hold", out_left, col_w(0, 0, 0));
        check("stall_col", 64'(out_col), 0);

        // reset with both banks full and overflow set
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_valid", 64'(out_valid), 0);
        check("rst2_left", out_left, 0);
        check("rst2_right", out_right, 0);
        check("rst2_col", 64'(out_col), 0);
        check("rst2_last", 64'(out_last), 0);
        check("rst2_ovf", 64'(overflow), 0);
        check("rst2_rdy", 64'(in_ready), 1);

        // toggling out_ready during drain
        gb = 3; exp_n = 0;
        for (int r = 0; r < 4; r++) drive(3, r);
        in_valid = 1'b0;
        for (int j = 0; j < 20 && exp_n < 4; j++) begin
            out_ready = (j % 2 == 0);
            acc();
            tick();
        end
        check("tog_count", 64'(exp_n), 4);
        out_ready = 1'b1;
        tick();
        check("tog_done", 64'(out_valid), 0);

        // calc_init mid-drain, colliding with a dropped word
        gb = 4; exp_n = 0;
        for (int r = 0; r < 4; r++) drive(4, r);
        in_valid = 1'b0;
        for (int j = 0; j < 10 && exp_n < 2; j++) begin
            acc();
            tick();
        end
        check("mid_cols", 64'(exp_n), 2);
        calc_init = 1'b1;
        in_valid  = 1'b1;
        in_data_a = row_w(9, 0, 0);
        in_data_s = row_w(9, 0, 1);
        tick();
        calc_init = 1'b0;
        in_valid  = 1'b0;
        check("init_valid", 64'(out_valid), 0);
        check("init_ovf", 64'(overflow), 0);
        check("init_rdy", 64'(in_ready), 1);
        gb = 5; exp_n = 0;
        for (int r = 0; r < 4; r++) drive(5, r);
        in_valid = 1'b0;
        for (int j = 0; j < 12 && exp_n < 4; j++) begin
            acc();
            tick();
        end
        check("init_count", 64'(exp_n), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
